game_ctrl: RTL and testbench

Game sequencer for the Pong datapath. Owns ball position, ball velocity and both player scores, and advances them once per video frame. Drives the `ball` and `score` buses that `disp` draws (replacing the constant placeholders), and gates paddle movement in `inp` via `input_enable`. Sits in `top` on `clk_25`, between `inp`/`vga` (sources) and `disp` (sink).

---
 rtl/pong_pkg.sv | 25 ++
 rtl/game_ctrl_ball_step.sv | 80 ++++++++
 rtl/game_ctrl.sv | 162 ++++++++++++++++
 tb/tb_game_ctrl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared Pong definitions: screen geometry, sequencer state encoding and
// packed bus widths used by game_ctrl, disp and the top level.
package pong_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;

  localparam int COORD_W = 10;
  localparam int DIGIT_W = 4;
  localparam int BALL_W  = 2 * COORD_W;
  localparam int SCORE_W = 2 * DIGIT_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SERVE = 2'd1,
    ST_PLAY  = 2'd2,
    ST_OVER  = 2'd3
  } state_t;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;
  localparam logic DIR_UP    = 1'b0;
  localparam logic DIR_DOWN  = 1'b1;

endpackage

// File: rtl/game_ctrl_ball_step.sv
// Combinational one-frame ball advance: wall bounce, paddle hits and misses.
module ball_step #(
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480,
  parameter int BALL_SIZE = 8,
  parameter int PADDLE_W  = 8,
  parameter int PADDLE_H  = 64,
  parameter int P1_X      = 16,
  parameter int P2_X      = 616,
  parameter int SPEED_X   = 2,
  parameter int SPEED_Y   = 1
) (
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic       dir_x,
  input  logic       dir_y,
  input  logic [9:0] p1pos,
  input  logic [9:0] p2pos,
  output logic [9:0] next_x,
  output logic [9:0] next_y,
  output logic       next_dir_x,
  output logic       next_dir_y,
  output logic       hit_left,
  output logic       hit_right,
  output logic       miss_left,
  output logic       miss_right
);
  import pong_pkg::*;

  localparam logic signed [10:0] SX      = 11'(SPEED_X);
  localparam logic signed [10:0] SY      = 11'(SPEED_Y);
  localparam logic signed [10:0] BS      = 11'(BALL_SIZE);
  localparam logic signed [10:0] X_MAX   = 11'(H_ACTIVE - BALL_SIZE);
  localparam logic signed [10:0] Y_MAX   = 11'(V_ACTIVE - BALL_SIZE);
  localparam logic signed [10:0] P1_EDGE = 11'(P1_X + PADDLE_W);
  localparam logic signed [10:0] P2_EDGE = 11'(P2_X);

  logic signed [10:0] xs, ys, nx, ny;
  logic               ov1, ov2;

  always_comb begin
    xs = signed'({1'b0, x});
    ys = signed'({1'b0, y});
    ny = (dir_y == DIR_DOWN) ? ys + SY : ys - SY;
    nx = (dir_x == DIR_RIGHT) ? xs + SX : xs - SX;

    next_y     = ny[9:0];
    next_dir_y = dir_y;
    if (ny < 0) begin
      next_y     = '0;
      next_dir_y = ~dir_y;
    end else if (ny > Y_MAX) begin
      next_y     = Y_MAX[9:0];
      next_dir_y = ~dir_y;
    end

    // 12-bit unsigned so paddle bottom (pos+height) cannot wrap
    ov1 = ({2'b0, y} + 12'(BALL_SIZE) > {2'b0, p1pos}) &&
          ({2'b0, y} < {2'b0, p1pos} + 12'(PADDLE_H));
    ov2 = ({2'b0, y} + 12'(BALL_SIZE) > {2'b0, p2pos}) &&
          ({2'b0, y} < {2'b0, p2pos} + 12'(PADDLE_H));

    hit_left  = (dir_x == DIR_LEFT) && (xs >= P1_EDGE) && (nx < P1_EDGE) && ov1;
    hit_right = (dir_x == DIR_RIGHT) && (xs + BS <= P2_EDGE) &&
                (nx + BS > P2_EDGE) && ov2;
    miss_left  = !hit_left && !hit_right && (nx < 0);
    miss_right = !hit_left && !hit_right && (nx > X_MAX);

    next_x     = nx[9:0];
    next_dir_x = dir_x;
    if (hit_left) begin
      next_x     = P1_EDGE[9:0];
      next_dir_x = DIR_RIGHT;
    end else if (hit_right) begin
      next_x     = 10'(P2_X - BALL_SIZE);
      next_dir_x = DIR_LEFT;
    end
  end

endmodule

// File: rtl/game_ctrl.sv
// Pong game sequencer: owns ball position/velocity and scores, advancing
// them once per frame_tick rising edge through IDLE/SERVE/PLAY/OVER.
module game_ctrl #(
  parameter int H_ACTIVE     = pong_pkg::H_ACTIVE,
  parameter int V_ACTIVE     = pong_pkg::V_ACTIVE,
  parameter int BALL_SIZE    = 8,
  parameter int PADDLE_W     = 8,
  parameter int PADDLE_H     = 64,
  parameter int P1_X         = 16,
  parameter int P2_X         = 616,
  parameter int SPEED_X      = 2,
  parameter int SPEED_Y      = 1,
  parameter int SERVE_FRAMES = 60,
  parameter int WIN_SCORE    = 9
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        frame_tick,
  input  logic                        start,
  input  logic [9:0]                  p1pos,
  input  logic [9:0]                  p2pos,
  output logic [pong_pkg::BALL_W-1:0]  ball,
  output logic [pong_pkg::SCORE_W-1:0] score,
  output logic                        input_enable,
  output logic                        game_over
);
  import pong_pkg::*;

  localparam int              CNT_W = $clog2(SERVE_FRAMES + 1);
  localparam logic [9:0]      CX    = 10'(H_ACTIVE / 2 - BALL_SIZE / 2);
  localparam logic [9:0]      CY    = 10'(V_ACTIVE / 2 - BALL_SIZE / 2);
  localparam logic [3:0]      WIN   = 4'(WIN_SCORE);
  localparam logic [CNT_W-1:0] LOAD = CNT_W'(SERVE_FRAMES);

  state_t           state, state_n;
  logic [9:0]       x, y, x_n, y_n;
  logic             dir_x, dir_y, dir_x_n, dir_y_n;
  logic [3:0]       p1_sc, p2_sc, p1_sc_n, p2_sc_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             tick_q, tick, ie_n, go_n;

  logic [9:0] st_x, st_y;
  logic       st_dx, st_dy, hit_l, hit_r, miss_l, miss_r;

  assign tick  = frame_tick & ~tick_q;
  assign ball  = {y, x};
  assign score = {p2_sc, p1_sc};

  ball_step #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .BALL_SIZE(BALL_SIZE),
    .PADDLE_W (PADDLE_W),
    .PADDLE_H (PADDLE_H),
    .P1_X     (P1_X),
    .P2_X     (P2_X),
    .SPEED_X  (SPEED_X),
    .SPEED_Y  (SPEED_Y)
  ) u_step (
    .x         (x),
    .y         (y),
    .dir_x     (dir_x),
    .dir_y     (dir_y),
    .p1pos     (p1pos),
    .p2pos     (p2pos),
    .next_x    (st_x),
    .next_y    (st_y),
    .next_dir_x(st_dx),
    .next_dir_y(st_dy),
    .hit_left  (hit_l),
    .hit_right (hit_r),
    .miss_left (miss_l),
    .miss_right(miss_r)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= ST_IDLE;
      x            <= CX;
      y            <= CY;
      dir_x        <= DIR_RIGHT;
      dir_y        <= DIR_DOWN;
      p1_sc        <= '0;
      p2_sc        <= '0;
      cnt          <= '0;
      tick_q       <= 1'b0;
      input_enable <= 1'b0;
      game_over    <= 1'b0;
    end else begin
      state        <= state_n;
      x            <= x_n;
      y            <= y_n;
      dir_x        <= dir_x_n;
      dir_y        <= dir_y_n;
      p1_sc        <= p1_sc_n;
      p2_sc        <= p2_sc_n;
      cnt          <= cnt_n;
      tick_q       <= frame_tick;
      input_enable <= ie_n;
      game_over    <= go_n;
    end
  end

  always_comb begin
    state_n = state;
    x_n     = x;
    y_n     = y;
    dir_x_n = dir_x;
    dir_y_n = dir_y;
    p1_sc_n = p1_sc;
    p2_sc_n = p2_sc;
    cnt_n   = cnt;

    unique case (state)
      ST_IDLE, ST_OVER: begin
        if (start) begin
          p1_sc_n = '0;
          p2_sc_n = '0;
          cnt_n   = LOAD;
          state_n = ST_SERVE;
        end
      end
      ST_SERVE: begin
        if (tick) begin
          if (cnt == '0) state_n = ST_PLAY;
          else           cnt_n   = cnt - CNT_W'(1);
        end
      end
      ST_PLAY: begin
        if (tick) begin
          y_n     = st_y;
          dir_y_n = st_dy;
          x_n     = st_x;
          dir_x_n = st_dx;
          // a point re-centres the ball and serves toward the player who lost it
          if (miss_l || miss_r) begin
            x_n = CX;
            y_n = CY;
            if (miss_l) begin
              p2_sc_n = p2_sc + 4'd1;
              dir_x_n = DIR_LEFT;
            end else begin
              p1_sc_n = p1_sc + 4'd1;
              dir_x_n = DIR_RIGHT;
            end
            if ((miss_l && p2_sc_n == WIN) || (miss_r && p1_sc_n == WIN)) begin
              state_n = ST_OVER;
            end else begin
              cnt_n   = LOAD;
              state_n = ST_SERVE;
            end
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase

    ie_n = (state_n == ST_SERVE) || (state_n == ST_PLAY);
    go_n = (state_n == ST_OVER);
  end

endmodule

// File: tb/tb_game_ctrl.sv
// Scoreboard bench for game_ctrl: a behavioural game model pushes expected
// outputs each cycle; they are popped and compared one time unit after the edge.
module tb_game_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        frame_tick = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  p1pos = '0;
  logic [9:0]  p2pos = '0;
  logic [19:0] ball;
  logic [7:0]  score;
  logic        input_enable;
  logic        game_over;

  always #20 clk = ~clk;

  game_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .frame_tick  (frame_tick),
    .start       (start),
    .p1pos       (p1pos),
    .p2pos       (p2pos),
    .ball        (ball),
    .score       (score),
    .input_enable(input_enable),
    .game_over   (game_over)
  );

  typedef struct {
    logic [19:0] ball;
    logic [7:0]  score;
    logic        ie;
    logic        go;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  // model state: 0 idle, 1 serve, 2 play, 3 over
  int m_st = 0, mx = 316, my = 236, mdx = 1, mdy = 1;
  int ms1 = 0, ms2 = 0, mcnt = 0, mtq = 0;

  localparam logic [19:0] CENTRE = {10'd236, 10'd316};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_step(input logic r, input logic s, input logic ft);
    int tk, nx, ny, ndy, p1, p2;
    bit ov1, ov2;
    if (!r) begin
      m_st = 0; mx = 316; my = 236; mdx = 1; mdy = 1;
      ms1 = 0; ms2 = 0; mcnt = 0; mtq = 0;
      return;
    end
    tk  = (ft && !mtq) ? 1 : 0;
    mtq = ft ? 1 : 0;
    p1  = int'(p1pos);
    p2  = int'(p2pos);
    case (m_st)
      0, 3: if (s) begin ms1 = 0; ms2 = 0; mcnt = 60; m_st = 1; end
      1: if (tk != 0) begin
           if (mcnt == 0) m_st = 2; else mcnt--;
         end
      default: if (tk != 0) begin
        ny = my + (mdy != 0 ? 1 : -1);
        ndy = mdy;
        if (ny < 0) begin ny = 0; ndy = 1 - mdy; end
        else if (ny > 472) begin ny = 472; ndy = 1 - mdy; end
        nx  = mx + (mdx != 0 ? 2 : -2);
        ov1 = (my + 8 > p1) && (my < p1 + 64);
        ov2 = (my + 8 > p2) && (my < p2 + 64);
        if (mdx == 0 && mx >= 24 && nx < 24 && ov1) begin
          mx = 24; mdx = 1; my = ny; mdy = ndy;
        end else if (mdx == 1 && mx + 8 <= 616 && nx + 8 > 616 && ov2) begin
          mx = 608; mdx = 0; my = ny; mdy = ndy;
        end else if (nx < 0) begin
          ms2++; mx = 316; my = 236; mdx = 0; mdy = ndy;
          if (ms2 == 9) m_st = 3; else begin mcnt = 60; m_st = 1; end
        end else if (nx > 632) begin
          ms1++; mx = 316; my = 236; mdx = 1; mdy = ndy;
          if (ms1 == 9) m_st = 3; else begin mcnt = 60; m_st = 1; end
        end else begin
          mx = nx; my = ny; mdy = ndy;
        end
      end
    endcase
  endtask

  task automatic cycle(input logic r, input logic s, input logic ft);
    exp_t e;
    rst = r;
    start = s;
    frame_tick = ft;
    model_step(r, s, ft);
    e.ball  = {10'(my), 10'(mx)};
    e.score = {4'(ms2), 4'(ms1)};
    e.ie    = (m_st == 1 || m_st == 2);
    e.go    = (m_st == 3);
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check("ball", ball, e.ball);
      check("score", score, e.score);
      check("input_enable", input_enable, e.ie);
      check("game_over", game_over, e.go);
    end
  endtask

  // mode 0: both paddles track the ball; 1: p1 away; 2: p2 away
  task automatic frame(input int hold, input int mode);
    int track, away;
    track = (my >= 20) ? my - 20 : 0;
    away  = (my < 200) ? 400 : 0;
    p1pos = 10'((mode == 1) ? away : track);
    p2pos = 10'((mode == 2) ? away : track);
    for (int i = 0; i < hold; i++) cycle(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1);
    check("rst_ball", ball, CENTRE);
    check("rst_score", score, 8'h00);
    check("rst_ie", input_enable, 1'b0);
    check("rst_over", game_over, 1'b0);

    cycle(1'b1, 1'b0, 1'b0);
    check("idle_ie", input_enable, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    check("start_ie", input_enable, 1'b1);

    for (int i = 0; i < 60; i++) frame(1, 0);
    check("serve60_ball", ball, CENTRE);
    frame(2, 0);
    check("tick61_ball", ball, CENTRE);
    frame(1, 0);
    check("tick62_ball", ball, {10'd237, 10'd318});

    for (int i = 0; i < 1000; i++) frame(1 + (i % 3), 0);
    check("rally_score", score, 8'h00);

    for (int i = 0; i < 400 && ms2 == 0; i++) frame(1, 1);
    check("p2_point_score", score, 8'h10);
    check("p2_point_ball", ball, CENTRE);
    check("p2_point_ie", input_enable, 1'b1);

    for (int i = 0; i < 3000 && m_st != 3; i++) frame(1 + (i % 2), 2);
    check("win_score", score, 8'h19);
    check("win_over", game_over, 1'b1);
    check("win_ie", input_enable, 1'b0);
    frame(1, 2);
    check("over_hold", score, 8'h19);

    cycle(1'b1, 1'b1, 1'b1);
    check("restart_score", score, 8'h00);
    check("restart_ie", input_enable, 1'b1);
    check("restart_over", game_over, 1'b0);
    for (int i = 0; i < 120; i++) frame(1, 0);

    cycle(1'b0, 1'b1, 1'b1);
    check("midplay_rst_ball", ball, CENTRE);
    check("midplay_rst_score", score, 8'h00);
    check("midplay_rst_ie", input_enable, 1'b0);
    cycle(1'b1, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b0);
    check("post_rst_ball", ball, CENTRE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
